// File: rtl/store_narrow_rmw.sv
// Store-path narrowing unit: merges sb/sh into a word via read-modify-write
// against a data RAM without byte enables; sw is written straight through.
module store_narrow_rmw #(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t           state, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [15:0]      data_q, data_d;
  logic             half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_addr_d, mem_wdata_d;
  logic [31:0]      merged;
  logic [1:0]       pos;
  logic             bad_req;
  logic             timeout_hit;

  assign req_ready = (state == IDLE);

  assign bad_req = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]));

  assign timeout_hit = (TIMEOUT != 0) &&
                       (({1'b0, cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT));

  // Lane merge: big-endian mirrors the byte position within the word.
  always_comb begin
    merged = mem_rdata;
    pos    = BIG_ENDIAN ? ~lane_q : lane_q;
    if (half_q) begin
      if (lane_q[1] ^ BIG_ENDIAN) merged[31:16] = data_q;
      else                        merged[15:0]  = data_q;
    end else begin
      merged[{pos, 3'b000} +: 8] = data_q[7:0];
    end
  end

  // Next-state and next-output logic; outputs are registered from state_d.
  always_comb begin
    state_d     = state;
    lane_d      = lane_q;
    data_d      = data_q;
    half_d      = half_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          lane_d     = req_addr[1:0];
          data_d     = req_data[15:0];
          half_d     = (req_size == 2'b01);
          cnt_d      = '0;
          mem_addr_d = {req_addr[31:2], 2'b00};
          if (bad_req) begin
            state_d = ERR;
          end else if (req_size == 2'b10) begin
            state_d     = WRITE;
            mem_wdata_d = req_data;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // rvalid takes priority over a coincident timeout.
        if (mem_rvalid) begin
          state_d     = WRITE;
          mem_wdata_d = merged;
          cnt_d       = '0;
        end else if (timeout_hit) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane_q    <= '0;
      data_q    <= '0;
      half_q    <= 1'b0;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      lane_q    <= lane_d;
      data_q    <= data_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_re    <= (state_d == READ);
      mem_we    <= (state_d == WRITE);
      done      <= (state_d == DONE);
      err       <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Scoreboard bench: little- and big-endian instances share stimulus; a forked
// monitor pops expected write/done/err events and a responder models RAM latency.
module tb_store_narrow_rmw;

  typedef struct {
    int          kind;   // 0 write, 1 done, 2 err
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;

  logic        rdy_o   [2];
  logic        re_o    [2];
  logic        we_o    [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic [31:0] ma_o    [2];
  logic [31:0] wd_o    [2];
  logic        rvalid  [2];
  logic [31:0] mem_word;

  exp_t exp_q [2][$];
  int   rcnt   [2];
  int   re_cnt [2];
  int   rd_lat;
  int   ncyc = 0;
  int   total;
  int   bad;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    store_narrow_rmw #(
      .TIMEOUT   (4),
      .BIG_ENDIAN((g == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (rdy_o[g]),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_addr  (ma_o[g]),
      .mem_re    (re_o[g]),
      .mem_rvalid(rvalid[g]),
      .mem_rdata (mem_word),
      .mem_we    (we_o[g]),
      .mem_wdata (wd_o[g]),
      .done      (done_o[g]),
      .err       (err_o[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic handle(input int g, input int kind, input logic [31:0] ad, input logic [31:0] wdat);
    exp_t e;
    if (exp_q[g].size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event dut%0d: got kind %0d expected none (cyc %0d)", g, kind, ncyc);
    end else begin
      e = exp_q[g].pop_front();
      check($sformatf("ev_kind dut%0d", g), 32'(kind), 32'(e.kind));
      check($sformatf("ev_cycle dut%0d", g), 32'(ncyc), 32'(e.cyc));
      if (kind == 0) begin
        check($sformatf("we_addr dut%0d", g), ad, e.addr);
        check($sformatf("we_data dut%0d", g), wdat, e.data);
      end
    end
  endtask

  // Monitor and RAM responder, both sampled on the falling edge.
  task automatic bench_loop();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst_n) begin
          if (we_o[g])   handle(g, 0, ma_o[g], wd_o[g]);
          if (done_o[g]) handle(g, 1, 32'h0, 32'h0);
          if (err_o[g])  handle(g, 2, 32'h0, 32'h0);
        end
        if (!rst_n) begin
          rcnt[g]   = 0;
          rvalid[g] = 1'b0;
        end else if (re_o[g]) begin
          re_cnt[g]++;
          rcnt[g]++;
          rvalid[g] = (rd_lat != 0) && (rcnt[g] == rd_lat);
        end else begin
          rcnt[g]   = 0;
          rvalid[g] = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input int lat, input logic [31:0] rd,
                     input bit is_err, input int ev_cyc,
                     input logic [31:0] wd_le, input logic [31:0] wd_be,
                     input int exp_re, input int end_cyc, input bit hold);
    int   n;
    int   w;
    int   re0 [2];
    exp_t e;
    w = 0;
    while (!(rdy_o[0] && rdy_o[1]) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      total++;
      bad++;
      $display("FAIL %s ready_wait: got busy expected idle", nm);
      return;
    end
    rd_lat   = lat;
    mem_word = rd;
    n        = ncyc;
    if (is_err) begin
      e = '{2, 32'h0, 32'h0, n + ev_cyc};
      exp_q[0].push_back(e);
      exp_q[1].push_back(e);
    end else begin
      e = '{0, {a[31:2], 2'b00}, wd_le, n + ev_cyc};
      exp_q[0].push_back(e);
      e.data = wd_be;
      exp_q[1].push_back(e);
      e = '{1, 32'h0, 32'h0, n + ev_cyc + 1};
      exp_q[0].push_back(e);
      exp_q[1].push_back(e);
    end
    re0[0] = re_cnt[0];
    re0[1] = re_cnt[1];
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int g = 0; g < 2; g++) check($sformatf("%s busy dut%0d", nm, g), 32'(rdy_o[g]), 32'd0);
    // A held request while busy must be neither accepted nor captured.
    if (hold) begin
      req_valid = 1'b1;
      req_addr  = 32'h0;
      req_data  = 32'hFFFF_FFFF;
      req_size  = 2'b10;
      @(negedge clk);
      req_valid = 1'b0;
    end
    while (ncyc < n + end_cyc) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s ready dut%0d", nm, g), 32'(rdy_o[g]), 32'd1);
      check($sformatf("%s re_cycles dut%0d", nm, g), 32'(re_cnt[g] - re0[g]), 32'(exp_re));
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    mem_word  = '0;
    rd_lat    = 0;
    total     = 0;
    bad       = 0;
    for (int g = 0; g < 2; g++) begin
      rvalid[g] = 1'b0;
      rcnt[g]   = 0;
      re_cnt[g] = 0;
    end
    fork
      bench_loop();
    join_none

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst ready dut%0d", g), 32'(rdy_o[g]), 32'd1);
      check($sformatf("rst re dut%0d", g), 32'(re_o[g]), 32'd0);
      check($sformatf("rst we dut%0d", g), 32'(we_o[g]), 32'd0);
      check($sformatf("rst done dut%0d", g), 32'(done_o[g]), 32'd0);
      check($sformatf("rst err dut%0d", g), 32'(err_o[g]), 32'd0);
      check($sformatf("rst addr dut%0d", g), ma_o[g], 32'h0);
      check($sformatf("rst wdata dut%0d", g), wd_o[g], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    //  name       addr          data          sz     lat rdata        err ev  wd_le         wd_be         re end hold
    run("sw",      32'h100, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0,  1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 0);
    run("sb",      32'h203, 32'h123456AB, 2'b00, 2, 32'h11223344, 0,  3, 32'hAB223344, 32'h112233AB, 2, 5, 1);
    run("sh",      32'h302, 32'hFFFFCAFE, 2'b01, 1, 32'h89ABCDEF, 0,  2, 32'hCAFECDEF, 32'h89ABCAFE, 1, 4, 0);
    run("sh_lo",   32'h600, 32'h00001234, 2'b01, 1, 32'h0,        0,  2, 32'h00001234, 32'h12340000, 1, 4, 0);
    run("sb_lane0",32'h500, 32'h00000077, 2'b00, 3, 32'hFFFFFFFF, 0,  4, 32'hFFFFFF77, 32'h77FFFFFF, 3, 6, 0);
    run("sh_mis",  32'h301, 32'h0,        2'b01, 1, 32'h0,        1,  1, 32'h0,        32'h0,        0, 2, 0);
    run("sw_mis",  32'h302, 32'h0,        2'b10, 1, 32'h0,        1,  1, 32'h0,        32'h0,        0, 2, 0);
    run("sz11",    32'h300, 32'h0,        2'b11, 1, 32'h0,        1,  1, 32'h0,        32'h0,        0, 2, 0);
    run("tmo",     32'h400, 32'h00000055, 2'b00, 0, 32'h0,        1,  5, 32'h0,        32'h0,        4, 6, 0);
    run("tmo_edge",32'h401, 32'h000000A5, 2'b00, 4, 32'h11223344, 0,  5, 32'h1122A544, 32'h11A53344, 4, 7, 0);

    // Reset during READ: read strobe must drop without waiting for a clock.
    rd_lat    = 0;
    req_addr  = 32'h800;
    req_data  = 32'h0000_0011;
    req_size  = 2'b00;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("arst re dut%0d", g), 32'(re_o[g]), 32'd0);
      check($sformatf("arst ready dut%0d", g), 32'(rdy_o[g]), 32'd1);
      check($sformatf("arst we dut%0d", g), 32'(we_o[g]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run("sw_post", 32'h700, 32'h0BADF00D, 2'b10, 0, 32'h0,        0,  1, 32'h0BADF00D, 32'h0BADF00D, 0, 3, 0);

    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("leftover dut%0d", g), 32'(exp_q[g].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-path counterpart to the load-side sign/zero extenders.
- Takes a 32-bit register value plus store size (sb/sh/sw) and narrows it into the correct byte lanes of a word-wide data memory that has no byte enables.
- Sub-word stores use a read-modify-write sequence; word stores write directly.
- Sits between the CPU store stage and the data RAM; signals completion, misalignment errors and timeouts back to the CPU.

Parameters:
- TIMEOUT, 255, max cycles to wait for mem_rvalid in READ; 0 disables the timeout.
- BIG_ENDIAN, 0, lane order; 0 places byte at offset k in bits [8k+7:8k], 1 places it in bits [31-8k:24-8k].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  store request valid.
- req_ready  out  1  block idle, able to accept a request.
- req_addr  in  32  byte address.
- req_data  in  32  register value; only the low 8/16/32 bits are used.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_re  out  1  memory read request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- mem_we  out  1  memory write strobe, one cycle.
- mem_wdata  out  32  merged write word.
- done  out  1  one-cycle pulse: store completed.
- err  out  1  one-cycle pulse: misaligned, reserved-size or timeout.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, mem_re=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0, timeout counter=0; req_ready=1 (decoded from IDLE).
- All outputs except req_ready are registered. req_ready = (state==IDLE).
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: on req_valid&&req_ready, capture addr, data and size.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> ERR. No memory access occurs.
  - Word -> WRITE.
  - Byte/half -> READ.
- READ: mem_re=1 and mem_addr valid from the first READ cycle.
  - mem_re is held until mem_rvalid is sampled high. Then mem_rdata is captured, the merge is computed, and the next state is WRITE.
  - The counter increments each READ cycle without rvalid. When it reaches TIMEOUT (TIMEOUT!=0) -> ERR, with mem_re dropped.
- Merge rules:
  - Byte: lane addr[1:0] replaced by data[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} replaced by data[15:0], lane order per BIG_ENDIAN.
  - All other bits are kept from mem_rdata.
  - Word: mem_wdata = data; no read is performed.
- WRITE: mem_we=1 for exactly one cycle with mem_addr and mem_wdata stable -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE.
- Latency (accept edge = cycle 0):
  - Word: we in cycle 1, done in cycle 2, ready in cycle 3.
  - Byte/half with read latency L cycles (rvalid in cycle L, L>=1): we in cycle L+1, done in cycle L+2.
- Boundary conditions:
  - mem_rvalid outside READ is ignored.
  - req_valid outside IDLE is ignored; the request is not captured and must be held by the CPU.
  - rvalid in the same cycle the timeout is reached: rvalid wins -> WRITE.
  - rst_n low mid-operation: mem_we and mem_re drop immediately (async) and the block returns to IDLE. No partial write is ever issued after reset.
  - Captured request fields are immune to req_* changes after acceptance.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF -> mem_we=1 in cycle 1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; done in cycle 2; mem_re never asserts.
- sb addr=0x203, data=0x123456AB, mem_rdata=0x11223344, L=2 -> mem_re in cycles 1–2, mem_addr=0x200; mem_wdata=0xAB223344 (BIG_ENDIAN=0); done in cycle 4.
- sh addr=0x302, data=0xFFFFCAFE, mem_rdata=0x89ABCDEF -> mem_wdata=0xCAFECDEF. Rerun with BIG_ENDIAN=1 -> 0x89ABCAFE.
- sh addr=0x301 and sw addr=0x302 and size=11 -> each gives an err pulse in cycle 1, no mem_re/mem_we, req_ready back in cycle 2.
- TIMEOUT=4, sb with rvalid never asserted -> mem_re high for 4 cycles, then err pulse, no mem_we. Repeat with rvalid on the 4th cycle -> write proceeds, no err.
- Drop rst_n during READ (cycle 2 of sb) -> mem_re=0 asynchronously, state IDLE, req_ready=1, no mem_we afterwards; a subsequent sw completes normally.
